// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between the ALU and load sources.
// Default build uses fixed MEM priority with an ALU starvation guard; define WB_ROUND_ROBIN_EN for strict alternation.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_addr,
  input  logic [31:0]       alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        mem_addr,
  input  logic [31:0]       mem_data,
  output logic [4:0]        D_addr,
  output logic              load_enable,
  output logic [31:0]       D_data,
  output logic [CNT_W-1:0]  starve_cnt
);

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              grant_alu;
  logic              grant_mem;
  logic              grant_any;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;

`ifdef WB_ROUND_ROBIN_EN
  // ptr_q: 0 prefers MEM, 1 prefers ALU; the winner always yields preference next time.
  localparam logic PREF_MEM = 1'b0;
  localparam logic PREF_ALU = 1'b1;

  logic ptr_q, ptr_d;

  always_comb begin
    grant_mem = !wb_stall && mem_valid && (!alu_valid || (ptr_q == PREF_MEM));
    grant_alu = !wb_stall && alu_valid && (!mem_valid || (ptr_q == PREF_ALU));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_mem) begin
      ptr_d = PREF_ALU;
    end else if (grant_alu) begin
      ptr_d = PREF_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PREF_MEM;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign starve_cnt = '0;
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_alu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= LIMIT) begin
      return LIMIT;
    end
    return v + 1'b1;
  endfunction

  // A saturated counter hands the port to the ALU even against a pending load.
  assign force_alu = (cnt_q == LIMIT);

  always_comb begin
    grant_mem = !wb_stall && mem_valid && !(force_alu && alu_valid);
    grant_alu = !wb_stall && alu_valid && (!mem_valid || force_alu);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!wb_stall) begin
      if (!alu_valid || grant_alu) begin
        cnt_d = '0;
      end else begin
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_cnt = cnt_q;
`endif

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign grant_any = grant_alu || grant_mem;

  always_comb begin
    win_addr = mem_addr;
    win_data = mem_data;
    if (grant_alu) begin
      win_addr = alu_addr;
      win_data = alu_data;
    end
  end

  // Output stage: x0 writes are accepted but never raise the enable.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    we_d   = 1'b0;
    if (grant_any) begin
      addr_d = win_addr;
      data_d = win_data;
      we_d   = (win_addr != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
    end
  end

  assign D_addr      = addr_q;
  assign D_data      = data_q;
  assign load_enable = we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter in its default (fixed-priority) build.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_stall;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic [4:0]  D_addr;
  logic        load_enable;
  logic [31:0] D_data;
  logic [3:0]  starve_cnt;

  int checks;
  int failures;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .D_addr(D_addr), .load_enable(load_enable), .D_data(D_data), .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    wb_stall  = 1'b0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    #12;
    chk("rst_le", load_enable, 0);
    chk("rst_addr", D_addr, 0);
    chk("rst_data", D_data, 0);
    chk("rst_cnt", starve_cnt, 0);
    step();
    rst = 1'b0;
    step();

    // single ALU write
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    #1;
    chk("single_alu_ready", alu_ready, 1);
    chk("single_mem_ready", mem_ready, 0);
    step();
    alu_valid = 1'b0;
    chk("single_addr", D_addr, 5);
    chk("single_data", D_data, 32'h1234);
    chk("single_le", load_enable, 1);
    step();
    chk("single_le_drop", load_enable, 0);
    chk("single_addr_hold", D_addr, 5);

    // x0 drop
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFF_FFFF;
    #1;
    chk("x0_ready", mem_ready, 1);
    step();
    mem_valid = 1'b0;
    chk("x0_le", load_enable, 0);
    chk("x0_data", D_data, 32'hFFFF_FFFF);
    step();

    // conflict with starvation guard
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("conf_mem_ready", mem_ready, 1);
      chk("conf_alu_ready", alu_ready, 0);
      step();
      chk("conf_cnt", starve_cnt, i + 1);
      chk("conf_mem_addr", D_addr, 2);
      chk("conf_mem_le", load_enable, 1);
    end
    #1;
    chk("force_alu_ready", alu_ready, 1);
    chk("force_mem_ready", mem_ready, 0);
    step();
    chk("force_cnt", starve_cnt, 0);
    chk("force_addr", D_addr, 3);
    chk("force_data", D_data, 32'h33);
    step();
    chk("post_force_cnt", starve_cnt, 1);
    chk("post_force_addr", D_addr, 2);

    // stall holds counter and blocks grants
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_mem_ready", mem_ready, 0);
      chk("stall_alu_ready", alu_ready, 0);
      step();
      chk("stall_le", load_enable, 0);
      chk("stall_cnt", starve_cnt, 1);
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_mem_ready", mem_ready, 1);
    step();
    chk("unstall_le", load_enable, 1);
    chk("unstall_addr", D_addr, 2);
    chk("unstall_cnt", starve_cnt, 2);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    step();
    chk("idle_cnt_clear", starve_cnt, 0);

    // reset mid-stream
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
    step();
    step();
    chk("pre_rst_le", load_enable, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_le", load_enable, 0);
    chk("mid_rst_addr", D_addr, 0);
    chk("mid_rst_data", D_data, 0);
    chk("mid_rst_cnt", starve_cnt, 0);
    step();
    chk("rst_edge_le", load_enable, 0);
    rst = 1'b0;
    #1;
    chk("rearb_mem_ready", mem_ready, 1);
    step();
    chk("rearb_le", load_enable, 1);
    chk("rearb_addr", D_addr, 9);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    step();

    // same destination from both sources
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hA;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hB;
    #1;
    chk("same_mem_ready", mem_ready, 1);
    step();
    mem_valid = 1'b0;
    chk("same_first_data", D_data, 32'hA);
    chk("same_first_le", load_enable, 1);
    #1;
    chk("same_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    chk("same_second_addr", D_addr, 7);
    chk("same_second_data", D_data, 32'hB);
    chk("same_second_le", load_enable, 1);
    step();
    chk("same_done_le", load_enable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
